// File: rtl/generic_sram_line_en_pkg.sv
// generic_sram_line_en_pkg: shared widths and response-entry layout for the line-enable SRAM initiator.
// The write flag in the entry exists only with GENERIC_SRAM_LINE_EN_INITIATOR_WRITE_ACK_EN.
package generic_sram_line_en_pkg;
    localparam int DEF_ADDR_BITS = 10;
    localparam int DEF_DATA_BITS = 32;
    typedef struct packed {
`ifdef GENERIC_SRAM_LINE_EN_INITIATOR_WRITE_ACK_EN
        logic write;
`endif
        logic [DEF_DATA_BITS-1:0] rdata;
    } rsp_entry_t;
endpackage

// File: rtl/generic_sram_line_en_if.sv
// generic_sram_line_en_if: single-port line SRAM strobes with one-cycle read latency.
interface generic_sram_line_en_if #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32
);
    logic [ADDR_BITS-1:0] addr;
    logic                 write_en;
    logic                 read_en;
    logic [DATA_BITS-1:0] write_data;
    logic [DATA_BITS-1:0] read_data;
    modport master(output addr, write_en, read_en, write_data, input read_data);
    modport slave(input addr, write_en, read_en, write_data, output read_data);
endinterface

// File: rtl/generic_sram_line_en_rsp_fifo.sv
// generic_sram_line_en_rsp_fifo: synchronous FIFO of DEPTH entries with occupancy count.
module generic_sram_line_en_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= nxt(wptr);
            if (pop) rptr <= nxt(rptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end
    assign pop_data = mem[rptr];
endmodule

// File: rtl/generic_sram_line_en_initiator.sv
// generic_sram_line_en_initiator: request/response front end for a one-cycle-latency line SRAM.
// GENERIC_SRAM_LINE_EN_INITIATOR_WRITE_ACK_EN adds write-ack beats and the o_rsp_write port.
module generic_sram_line_en_initiator
    import generic_sram_line_en_pkg::*;
#(
    parameter int MEM_ADDR_BITS = DEF_ADDR_BITS,
    parameter int MEM_DATA_BITS = DEF_DATA_BITS,
    parameter int RSP_DEPTH     = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_write,
    input  logic [MEM_ADDR_BITS-1:0] i_req_addr,
    input  logic [MEM_DATA_BITS-1:0] i_req_wdata,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [MEM_DATA_BITS-1:0] o_rsp_rdata,
`ifdef GENERIC_SRAM_LINE_EN_INITIATOR_WRITE_ACK_EN
    output logic                     o_rsp_write,
`endif
    generic_sram_line_en_if.master   m
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    typedef struct packed {
`ifdef GENERIC_SRAM_LINE_EN_INITIATOR_WRITE_ACK_EN
        logic write;
`endif
        logic [MEM_DATA_BITS-1:0] rdata;
    } rsp_t;
    logic          acc;
    logic          rsp_acc;
    logic          pop;
    logic          pend;
    logic [CW-1:0] count;
    logic [CW:0]   credit;
    rsp_t          push_entry;
    rsp_t          head;
    assign acc = i_req_valid && o_req_ready;
    assign pop = o_rsp_valid && i_rsp_ready;
    // Entries already owed (buffered plus the beat in flight) after this cycle's pop.
    assign credit      = {1'b0, count} + (CW+1)'(pend) - (CW+1)'(pop);
    assign o_req_ready = i_rst_n && (credit < (CW+1)'(RSP_DEPTH));
    assign m.read_en    = acc && !i_req_write;
    assign m.write_en   = acc && i_req_write;
    assign m.addr       = i_req_addr;
    assign m.write_data = i_req_wdata;
`ifdef GENERIC_SRAM_LINE_EN_INITIATOR_WRITE_ACK_EN
    logic pend_write;
    assign rsp_acc = acc;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pend_write <= 1'b0;
        else pend_write <= acc && i_req_write;
    end
    assign push_entry.write = pend_write;
    assign push_entry.rdata = pend_write ? '0 : m.read_data;
    assign o_rsp_write      = head.write;
`else
    assign rsp_acc          = acc && !i_req_write;
    assign push_entry.rdata = m.read_data;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pend <= 1'b0;
        else pend <= rsp_acc;
    end
    generic_sram_line_en_rsp_fifo #(
        .DEPTH(RSP_DEPTH),
        .WIDTH($bits(rsp_t))
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (pend),
        .push_data(push_entry),
        .pop      (pop),
        .pop_data (head),
        .count    (count)
    );
    assign o_rsp_valid = (count != '0);
    assign o_rsp_rdata = head.rdata;
endmodule

// File: tb/tb_generic_sram_line_en_initiator.sv
// tb_generic_sram_line_en_initiator: directed stimulus with a queue-based response model checked every cycle.
module tb_generic_sram_line_en_initiator;
    localparam int AB = 10;
    localparam int DB = 32;
    localparam int DEPTH = 2;
    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          i_req_write = 1'b0;
    logic [AB-1:0] i_req_addr = '0;
    logic [DB-1:0] i_req_wdata = '0;
    logic          i_rsp_ready = 1'b0;
    logic          o_req_ready;
    logic          o_rsp_valid;
    logic [DB-1:0] o_rsp_rdata;
`ifdef GENERIC_SRAM_LINE_EN_INITIATOR_WRITE_ACK_EN
    logic          o_rsp_write;
`endif
    generic_sram_line_en_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) m();
    generic_sram_line_en_initiator #(
        .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB), .RSP_DEPTH(DEPTH)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_write(i_req_write),
        .i_req_addr (i_req_addr),
        .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata),
`ifdef GENERIC_SRAM_LINE_EN_INITIATOR_WRITE_ACK_EN
        .o_rsp_write(o_rsp_write),
`endif
        .m          (m)
    );
    always #5 i_clk = ~i_clk;

    // SRAM environment: one-cycle read latency.
    logic [DB-1:0] mem_arr [1<<AB];
    logic [DB-1:0] shadow  [1<<AB];
    always @(posedge i_clk) begin
        if (m.write_en) mem_arr[m.addr] <= m.write_data;
        if (m.read_en) m.read_data <= mem_arr[m.addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: every response-producing accept owes one beat, visible two cycles later, in order.
    typedef struct {
        logic [DB-1:0] data;
        logic          wr;
        int            acc_cyc;
    } exp_t;
    exp_t q[$];
    bit exp_valid, exp_ready, exp_pop, exp_acc;
    always @(negedge i_clk) begin
        cyc++;
        if (!i_rst_n) begin
            q.delete();
            chk("rst_ready", o_req_ready, 0);
            chk("rst_valid", o_rsp_valid, 0);
            chk("rst_strobes", {m.read_en, m.write_en}, 0);
        end else begin
            exp_valid = q.size() > 0 && q[0].acc_cyc + 2 <= cyc;
            exp_pop   = exp_valid && i_rsp_ready;
            exp_ready = (q.size() - int'(exp_pop)) < DEPTH;
            exp_acc   = i_req_valid && exp_ready;
            chk("rsp_valid", o_rsp_valid, exp_valid);
            chk("req_ready", o_req_ready, exp_ready);
            chk("read_en", m.read_en, exp_acc && !i_req_write);
            chk("write_en", m.write_en, exp_acc && i_req_write);
            if (exp_acc) chk("m_addr", m.addr, i_req_addr);
            if (exp_acc && i_req_write) chk("m_wdata", m.write_data, i_req_wdata);
            if (exp_valid) begin
                chk("rsp_rdata", o_rsp_rdata, q[0].data);
`ifdef GENERIC_SRAM_LINE_EN_INITIATOR_WRITE_ACK_EN
                chk("rsp_write", o_rsp_write, q[0].wr);
`endif
            end
            if (exp_pop) void'(q.pop_front());
            if (exp_acc) begin
                if (i_req_write) begin
                    shadow[i_req_addr] = i_req_wdata;
`ifdef GENERIC_SRAM_LINE_EN_INITIATOR_WRITE_ACK_EN
                    q.push_back('{data: '0, wr: 1'b1, acc_cyc: cyc});
`endif
                end else begin
                    q.push_back('{data: shadow[i_req_addr], wr: 1'b0, acc_cyc: cyc});
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [AB-1:0] a, input logic [DB-1:0] d, output logic rd_seen);
        bit done = 0;
        i_req_valid = 1'b1;
        i_req_write = w;
        i_req_addr  = a;
        i_req_wdata = d;
        rd_seen     = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge i_clk);
            if (o_req_ready) begin
                rd_seen = m.read_en;
                done = 1;
            end
            @(posedge i_clk);
            #1;
        end
        i_req_valid = 1'b0;
        if (!done) chk("issue_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        i_req_valid = 1'b0;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    logic seen;
    int   start, n, np, nv;
    initial begin
        for (int i = 0; i < (1 << AB); i++) begin
            mem_arr[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
            shadow[i]  = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post_rst_ready", o_req_ready, 1);
        chk("post_rst_valid", o_rsp_valid, 0);
        chk("post_rst_strobes", {m.read_en, m.write_en}, 0);
        @(posedge i_clk);
        #1;
        // single write then read of address 5
        i_rsp_ready = 1'b1;
        issue(1'b1, 10'd5, 32'hDEAD_BEEF, seen);
        chk("wr_no_read_en", seen, 0);
        issue(1'b0, 10'd5, '0, seen);
        chk("rd_en_accept", seen, 1);
        @(negedge i_clk);
`ifndef GENERIC_SRAM_LINE_EN_INITIATOR_WRITE_ACK_EN
        chk("rd_t1_valid", o_rsp_valid, 0);
`endif
        @(negedge i_clk);
        chk("rd_t2_valid", o_rsp_valid, 1);
        chk("rd_t2_data", o_rsp_rdata, 32'hDEAD_BEEF);
        idle(3);
        // back-to-back: fill 0..7, then 8 reads with consumer always ready
        for (int i = 0; i < 8; i++) issue(1'b1, AB'(i), 32'h1000_0000 + i, seen);
        start = cyc;
        for (int i = 0; i < 8; i++) issue(1'b0, AB'(i), '0, seen);
        chk("b2b_cycles", cyc - start, 8);
        idle(4);
        // backpressure
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b1;
        i_req_write = 1'b0;
        i_req_addr  = 10'd40;
        n = 0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_req_ready) n++;
            @(posedge i_clk);
            #1;
            i_req_addr = i_req_addr + 1'b1;
        end
        chk("bp_accepts", n, DEPTH);
        @(negedge i_clk);
        chk("bp_ready_low", o_req_ready, 0);
        chk("bp_valid_held", o_rsp_valid, 1);
        chk("bp_head_data", o_rsp_rdata, (40 * 32'h0101_0101) ^ 32'hA5A5_0000);
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        np = 0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_rsp_valid) np++;
        end
        chk("bp_drained", np, DEPTH);
        idle(2);
        // reset in the cycle after a read accept
        issue(1'b0, 10'd9, '0, seen);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_mid_ready", o_req_ready, 1);
        nv = 0;
        repeat (5) begin
            if (o_rsp_valid) nv++;
            @(negedge i_clk);
        end
        chk("rst_mid_no_rsp", nv, 0);
        chk("rst_mid_count", dut.u_fifo.count, 0);
        @(posedge i_clk);
        #1;
        // write ack behaviour
        issue(1'b1, 10'd3, 32'h1234_5678, seen);
        @(negedge i_clk);
        @(negedge i_clk);
`ifdef GENERIC_SRAM_LINE_EN_INITIATOR_WRITE_ACK_EN
        chk("wack_valid", o_rsp_valid, 1);
        chk("wack_write", o_rsp_write, 1);
        chk("wack_rdata", o_rsp_rdata, 0);
`else
        chk("wack_none", o_rsp_valid, 0);
`endif
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
